// File: rtl/moltiplicatore_seq.sv
// moltiplicatore_seq: sequential shift-add multiplier, N-bit operands, 2N-bit product.
// Signed mode multiplies magnitudes and negates the result in a final fix-up step.
module moltiplicatore_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] ris,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]   ONE_N = 1;
    localparam logic [2*N-1:0] ONE_W = 1;
    localparam logic [CW-1:0]  ONE_C = 1;
    localparam logic [CW-1:0]  LAST  = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] ris_q, ris_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [N-1:0]   a_mag, b_mag;

    // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which fits unsigned.
    always_comb begin
        a_mag = (signed_mode && a[N-1]) ? (~a + ONE_N) : a;
        b_mag = (signed_mode && b[N-1]) ? (~b + ONE_N) : b;
    end

    // Next-state and datapath: load in IDLE, N add/shift steps, then sign fix-up.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        ris_d    = ris_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = signed_mode & (a[N-1] ^ b[N-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + ONE_C;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                ris_d   = neg_q ? (~acc_q + ONE_W) : acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ris_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            ris_q    <= ris_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ris  = ris_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_moltiplicatore_seq.sv
// tb_moltiplicatore_seq: checks N=8, N=2 and N=16 instances against
// an arithmetic reference product.
module tb_moltiplicatore_seq;

    logic clk;
    logic rst_n;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] ris8;
    logic        busy8, done8;

    logic        start2, sm2;
    logic [1:0]  a2, b2;
    logic [3:0]  ris2;
    logic        busy2, done2;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] ris16;
    logic        busy16, done16;

    int checks;
    int errors;
    int ndone16;

    moltiplicatore_seq #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .ris(ris8), .busy(busy8), .done(done8)
    );

    moltiplicatore_seq #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
        .a(a2), .b(b2), .ris(ris2), .busy(busy2), .done(done2)
    );

    moltiplicatore_seq #(.N(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .ris(ris16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done16) ndone16++;
    end

    // Reference: interpret operands as integers, multiply, keep 2n bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic sm, input int n);
        longint sx, sy, p;
        logic [63:0] r;
        sx = longint'(x);
        sy = longint'(y);
        if (sm) begin
            if (x[n-1]) sx = sx - (longint'(1) << n);
            if (y[n-1]) sy = sy - (longint'(1) << n);
        end
        p = sx * sy;
        r = p;
        if (2 * n < 64) r = r & ((64'd1 << (2 * n)) - 64'd1);
        return r;
    endfunction

    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic smi,
                       output logic [15:0] r, output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; a8 = ai; b8 = bi; sm8 = smi;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        lat = 1;
        bcnt = 0;
        while (!done8 && lat < 64) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = ris8;
    endtask

    task automatic test_reset;
        logic [15:0] r;
        int lat, bc;
        checks++;
        if (ris8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ris=%h busy=%b done=%b, want 0 0 0", ris8, busy8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'd5, 8'd5, 1'b0, r, lat, bc);
        checks++;
        if (r !== 16'd25) begin
            errors++;
            $display("FAIL pre_reset_op: ris=%h want %h", r, 16'd25);
        end
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ris8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: ris=%h busy=%b done=%b, want 0 0 0", ris8, busy8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'd7, 8'd6, 1'b0, r, lat, bc);
        checks++;
        if (r !== 16'h002A || lat !== 10) begin
            errors++;
            $display("FAIL after_reset_op: ris=%h lat=%0d, want 002a lat=10", r, lat);
        end
    endtask

    task automatic test_unsigned_corner;
        logic [15:0] r;
        int lat, bc;
        op8(8'd255, 8'd255, 1'b0, r, lat, bc);
        checks++;
        if (r !== 16'hFE01 || lat !== 10 || bc !== 9) begin
            errors++;
            $display("FAIL unsigned_corner: ris=%h lat=%0d busy=%0d, want fe01 10 9", r, lat, bc);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || ris8 !== 16'hFE01) begin
            errors++;
            $display("FAIL done_width: done=%b ris=%h, want 0 fe01", done8, ris8);
        end
    endtask

    task automatic test_signed;
        logic [7:0]  ta [8];
        logic [7:0]  tb [8];
        logic [15:0] r, exp;
        int lat, bc;
        ta[0] = 8'hFD; tb[0] = 8'h05;
        ta[1] = 8'h80; tb[1] = 8'h80;
        ta[2] = 8'h80; tb[2] = 8'h01;
        ta[3] = 8'hFD; tb[3] = 8'h00;
        ta[4] = 8'h7F; tb[4] = 8'h80;
        for (int i = 5; i < 8; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(ref_mul(32'(ta[i]), 32'(tb[i]), 1'b1, 8));
            op8(ta[i], tb[i], 1'b1, r, lat, bc);
            checks++;
            if (r !== exp || lat !== 10) begin
                errors++;
                $display("FAIL signed_%0d: %h*%h ris=%h lat=%0d, want %h lat=10",
                         i, ta[i], tb[i], r, lat, exp);
            end
        end
    endtask

    task automatic test_handshake;
        int k, nd;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd12; b8 = 8'd12; sm8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 64) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done8 !== 1'b1 || ris8 !== 16'd144) begin
            errors++;
            $display("FAIL busy_start_ignored: done=%b ris=%h, want 1 0090", done8, ris8);
        end
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle_start: done=%b busy=%b, want 0 1", done8, busy8);
        end
        k = 1;
        while (!done8 && k < 64) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ris8 !== 16'd81 || k !== 10) begin
            errors++;
            $display("FAIL back_to_back: ris=%h lat=%0d, want 0051 10", ris8, k);
        end
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        checks++;
        if (nd !== 0 || ris8 !== 16'd81) begin
            errors++;
            $display("FAIL no_queued_op: extra_done=%0d ris=%h, want 0 0051", nd, ris8);
        end
    endtask

    task automatic test_small_width;
        logic [3:0] exp;
        int k;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    exp = 4'(ref_mul(32'(x), 32'(y), 1'(s), 2));
                    @(negedge clk);
                    start2 = 1'b1; a2 = 2'(x); b2 = 2'(y); sm2 = 1'(s);
                    @(negedge clk);
                    start2 = 1'b0;
                    k = 1;
                    while (!done2 && k < 64) begin
                        @(negedge clk);
                        k++;
                    end
                    checks++;
                    if (ris2 !== exp || k !== 4) begin
                        errors++;
                        $display("FAIL n2_s%0d_%0dx%0d: ris=%h lat=%0d, want %h lat=4",
                                 s, x, y, ris2, k, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] ai, bi;
        logic        smi;
        logic [31:0] exp;
        int k, gap;
        @(negedge clk);
        ndone16 = 0;
        for (int i = 0; i < 2000; i++) begin
            ai = 16'($urandom);
            bi = 16'($urandom);
            smi = (i >= 1000);
            exp = 32'(ref_mul(32'(ai), 32'(bi), smi, 16));
            start16 = 1'b1; a16 = ai; b16 = bi; sm16 = smi;
            @(negedge clk);
            start16 = 1'b0;
            k = 1;
            while (!done16 && k < 64) begin
                if ($urandom_range(0, 3) == 0) begin
                    start16 = 1'b1;
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    sm16 = 1'($urandom);
                end else begin
                    start16 = 1'b0;
                end
                @(negedge clk);
                k++;
            end
            start16 = 1'b0;
            checks++;
            if (done16 !== 1'b1 || ris16 !== exp || k !== 18) begin
                errors++;
                $display("FAIL rand16_%0d: %h*%h s=%b ris=%h lat=%0d, want %h lat=18",
                         i, ai, bi, smi, ris16, k, exp);
            end
            gap = $urandom_range(0, 3);
            if (gap != 0) repeat (gap) @(negedge clk);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (ndone16 !== 2000) begin
            errors++;
            $display("FAIL rand16_done_count: dones=%0d want 2000", ndone16);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0;
        errors = 0;
        ndone16 = 0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        test_reset;
        test_unsigned_corner;
        test_signed;
        test_handshake;
        test_small_width;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moltiplicatore_seq.md
Name: moltiplicatore_seq

Overview:
Parametrised sequential shift-add multiplier. It is the clocked successor of the 2-bit combinational moltiplicatore.
- Accepts N-bit operands through a start/done handshake.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Produces a 2N-bit product after a fixed latency.
- Intended as the shared arithmetic unit for datapath exercises where a combinational array multiplier is too large.

Parameters:
N, 8, operand width in bits (legal range 2..32); product width is 2N.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge only while idle
signed_mode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled with start
a  input  N  multiplicand; sampled with start
b  input  N  multiplier; sampled with start
ris  output  2N  product; registered, holds the last result until the next completion
busy  output  1  high from the edge that accepts start until the edge that raises done
done  output  1  single-cycle completion pulse; ris is valid in that cycle

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ris=0, busy=0, done=0, all internal registers cleared.
- Reset mid-operation aborts the operation with no partial result visible. The first start after rst_n rises is accepted normally.
- States: IDLE, RUN, FIX.
- IDLE:
  - done=0 except the cycle immediately after FIX.
  - On rising edge with start=1, latch the operands:
    - Magnitude |a| and |b| as N-bit unsigned values; in unsigned mode magnitude = raw value.
    - neg = signed_mode & (a[N-1] ^ b[N-1]).
  - Clear the 2N-bit accumulator, load counter=0, go to RUN, set busy=1.
- RUN (exactly N edges), per edge:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; counter+1.
  - No early termination: latency is independent of operand values.
- FIX (1 edge):
  - ris <= neg ? (~acc + 1) : acc, truncated to 2N bits.
  - done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge E0 → done=1 and ris valid in the cycle after edge E(N+1). One operation takes N+2 cycles start-to-start.
- done is high for exactly one cycle. ris keeps its value until the next FIX, including across ignored starts.
- Start while busy=1 is ignored. It is not queued, and a/b/signed_mode changes during RUN/FIX have no effect.
- Start asserted in the done cycle (state already IDLE) is accepted, which gives back-to-back operation with no bubble beyond FIX.
- Width rules:
  - Magnitude of the most-negative value (-2^(N-1)) is representable as an N-bit unsigned value.
  - Product magnitude is at most 2^(2N-2) in signed mode and (2^N-1)^2 in unsigned mode; both fit in 2N bits, so the datapath cannot overflow.
- Zero operands take full latency. A negative × zero product yields ris=0, not a negative zero.

Test Plan:
- Reset/idle: assert rst_n=0 mid-RUN after starting 200*3 (N=8) → ris=0, busy=0, done=0 immediately; the next start with 7*6 → ris=0x002A, done after N+2 edges.
- Unsigned corner: N=8, signed_mode=0, a=255, b=255 → ris=0xFE01 (65025); busy high for exactly 9 cycles; done one cycle wide.
- Signed: N=8, signed_mode=1:
  - a=0xFD (-3), b=5 → ris=0xFFF1 (-15).
  - a=0x80, b=0x80 → ris=0x4000.
  - a=0x80, b=0x01 → ris=0xFF80.
- Handshake: start with 12*12, then pulse start again with 1*1 at cycle 3 while busy → ris=144 only, single done. Then start asserted in the done cycle with 9*9 → accepted, ris=81 after N+2 cycles.
- Small-width regression: N=2, signed_mode=0, exhaustive a,b ∈ 0..3 → ris=a*b (e.g. 2*1=2, 3*2=6, 1*1=1, 0*0=0), checked against a behavioural model.
- Random: N=16, 1000 random operand pairs in each mode with random back-to-back/idle gaps → every done matches the reference product, and no done occurs without a preceding accepted start.
